// File: rtl/vga_timing_ctrl_if.sv
// Register bus between a host and the VGA timing controller.
// cs is held until ack; dat_o carries read data only while ack is high.
interface vga_timing_ctrl_if;
    logic        cs;
    logic        we;
    logic [3:0]  adr;
    logic [11:0] dat_i;
    logic [11:0] dat_o;
    logic        ack;

    modport master (output cs, we, adr, dat_i, input dat_o, ack);
    modport slave  (input cs, we, adr, dat_i, output dat_o, ack);
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA timing register block: 14 shadow words staged by the host and copied into the
// active set on the first end-of-frame after a commit, plus done/vbl interrupts.
module vga_timing_ctrl #(
    parameter int unsigned H_TOTAL = 800,
    parameter int unsigned V_TOTAL = 525
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vga_timing_ctrl_if.slave     bus,
    input  logic                 eof,
    input  logic                 vbl_int,
    output logic [167:0]         tim_o,
    output logic                 irq,
    output logic                 pending
);
    localparam int unsigned DW   = 12;
    localparam int unsigned NREG = 14;
    localparam int unsigned TW   = DW * NREG;
    localparam logic [3:0]  ADR_CTRL = 4'd14;
    localparam logic [3:0]  ADR_STAT = 4'd15;

    typedef enum logic [1:0] {S_IDLE, S_PENDING, S_APPLY} state_t;

    function automatic logic [DW-1:0] f_rst_val(input int unsigned idx);
        logic [DW-1:0] v;
        case (idx)
            0:       v = DW'(H_TOTAL);
            1:       v = DW'(V_TOTAL);
            2:       v = 12'd657;
            3:       v = 12'd753;
            4:       v = 12'd491;
            5:       v = 12'd493;
            6:       v = 12'd641;
            8:       v = 12'd481;
            10:      v = 12'd641;
            12:      v = 12'd481;
            default: v = 12'd1;
        endcase
        return v;
    endfunction

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_apply;
    logic          r_ack;
    logic [DW-1:0] r_dat_o;
    logic          r_pending;
    logic          r_done;
    logic          r_vbl;
    logic          r_done_ie;
    logic          r_vbl_ie;
    logic          r_irq;
    logic [DW-1:0] r_shadow [NREG];
    logic [DW-1:0] r_active [NREG];

    logic          w_cyc;
    logic          w_wr;
    logic          w_ctrl_wr;
    logic          w_stat_wr;
    logic          w_commit;
    logic          w_abort;
    logic          w_done_nxt;
    logic          w_vbl_nxt;
    logic          w_done_ie_nxt;
    logic          w_vbl_ie_nxt;
    logic          w_irq_nxt;
    logic [DW-1:0] w_rd_data;

    // A bus cycle is accepted on the edge where cs is seen with ack low
    assign w_cyc     = bus.cs & ~r_ack;
    assign w_wr      = w_cyc & bus.we;
    assign w_ctrl_wr = w_wr & (bus.adr == ADR_CTRL);
    assign w_stat_wr = w_wr & (bus.adr == ADR_STAT);
    assign w_commit  = w_ctrl_wr & bus.dat_i[0];
    assign w_abort   = w_ctrl_wr & bus.dat_i[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Abort outranks both a simultaneous commit and a simultaneous eof
    always_comb begin
        w_state_nxt = r_state;
        w_apply     = 1'b0;
        case (r_state)
            S_IDLE:    if (w_commit && !w_abort) w_state_nxt = S_PENDING;
            S_PENDING: begin
                if (w_abort)  w_state_nxt = S_IDLE;
                else if (eof) w_state_nxt = S_APPLY;
            end
            S_APPLY: begin
                w_apply     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Hardware set wins over a software clear in the same cycle
    always_comb begin
        w_done_nxt    = w_apply | (r_done & ~(w_stat_wr & bus.dat_i[1]));
        w_vbl_nxt     = vbl_int | (r_vbl  & ~(w_stat_wr & bus.dat_i[2]));
        w_done_ie_nxt = w_ctrl_wr ? bus.dat_i[1] : r_done_ie;
        w_vbl_ie_nxt  = w_ctrl_wr ? bus.dat_i[2] : r_vbl_ie;
        w_irq_nxt     = (w_done_nxt & w_done_ie_nxt) | (w_vbl_nxt & w_vbl_ie_nxt);
    end

    always_comb begin
        w_rd_data = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (bus.adr == 4'(i)) w_rd_data = r_shadow[i];
        end
        if (bus.adr == ADR_CTRL) w_rd_data = DW'({r_vbl_ie, r_done_ie, 1'b0});
        if (bus.adr == ADR_STAT) w_rd_data = DW'({r_vbl, r_done, r_pending});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack     <= 1'b0;
            r_dat_o   <= '0;
            r_pending <= 1'b0;
            r_done    <= 1'b0;
            r_vbl     <= 1'b0;
            r_done_ie <= 1'b0;
            r_vbl_ie  <= 1'b0;
            r_irq     <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++) begin
                r_shadow[i] <= f_rst_val(i);
                r_active[i] <= f_rst_val(i);
            end
        end else begin
            r_ack     <= w_cyc;
            r_dat_o   <= w_cyc ? w_rd_data : '0;
            r_pending <= (w_state_nxt != S_IDLE);
            r_done    <= w_done_nxt;
            r_vbl     <= w_vbl_nxt;
            r_done_ie <= w_done_ie_nxt;
            r_vbl_ie  <= w_vbl_ie_nxt;
            r_irq     <= w_irq_nxt;
            // Apply copies the pre-edge shadow, so a write on the same edge waits for the next commit
            for (int unsigned i = 0; i < NREG; i++) begin
                if (w_wr && (bus.adr == 4'(i))) r_shadow[i] <= bus.dat_i;
                if (w_apply)                    r_active[i] <= r_shadow[i];
            end
        end
    end

    always_comb begin
        tim_o = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            tim_o[TW-1-DW*i -: DW] = r_active[i];
        end
    end

    assign bus.ack   = r_ack;
    assign bus.dat_o = r_dat_o;
    assign irq       = r_irq;
    assign pending   = r_pending;
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Randomized bench for vga_timing_ctrl: a transaction-level register model predicts
// read data (queued for a monitor) and the tim_o/pending/irq outputs.
module tb_vga_timing_ctrl;
    logic         clk;
    logic         rst_n;
    logic         eof;
    logic         vbl_int;
    logic [167:0] tim_o;
    logic         irq;
    logic         pending;

    vga_timing_ctrl_if bus();

    vga_timing_ctrl #(.H_TOTAL(800), .V_TOTAL(525)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .eof     (eof),
        .vbl_int (vbl_int),
        .tim_o   (tim_o),
        .irq     (irq),
        .pending (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [11:0] sb_q [$];

    // Reference model: register contents and flags as seen by software
    logic [11:0] m_shadow [14];
    logic [11:0] m_active [14];
    bit          m_pend, m_done, m_vbl, m_die, m_vie;

    task automatic chk(input string name, input logic [167:0] act, input logic [167:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] rst_val(input int i);
        logic [11:0] t [14];
        t = '{12'd800, 12'd525, 12'd657, 12'd753, 12'd491, 12'd493, 12'd641,
              12'd1, 12'd481, 12'd1, 12'd641, 12'd1, 12'd481, 12'd1};
        return t[i];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 14; i++) begin
            m_shadow[i] = rst_val(i);
            m_active[i] = rst_val(i);
        end
        {m_pend, m_done, m_vbl, m_die, m_vie} = '0;
    endtask

    function automatic logic [11:0] m_read(input logic [3:0] a);
        if (a < 4'd14) return m_shadow[a];
        if (a == 4'd14) return {9'd0, m_vie, m_die, 1'b0};
        return {9'd0, m_vbl, m_done, m_pend};
    endfunction

    function automatic logic [167:0] m_tim();
        logic [167:0] t = '0;
        for (int i = 0; i < 14; i++) t = (t << 12) | 168'(m_active[i]);
        return t;
    endfunction

    function automatic bit m_irq();
        return (m_done & m_die) | (m_vbl & m_vie);
    endfunction

    task automatic m_apply();
        if (m_pend) begin
            for (int i = 0; i < 14; i++) m_active[i] = m_shadow[i];
            m_done = 1'b1;
            m_pend = 1'b0;
        end
    endtask

    task automatic m_write(input logic [3:0] a, input logic [11:0] d);
        if (a < 4'd14) m_shadow[a] = d;
        else if (a == 4'd14) begin
            m_die = d[1];
            m_vie = d[2];
            if (d[3])      m_pend = 1'b0;
            else if (d[0]) m_pend = 1'b1;
        end else begin
            if (d[1]) m_done = 1'b0;
            if (d[2]) m_vbl  = 1'b0;
        end
    endtask

    // Starts on a negedge; ends one negedge after ack so the next cycle starts clean
    task automatic bus_xfer(input bit w, input logic [3:0] a, input logic [11:0] d,
                            input bit eof_too, input bit vbl_too);
        int n;
        bit pre;
        if (!w) sb_q.push_back(m_read(a));
        bus.cs = 1'b1; bus.we = w; bus.adr = a; bus.dat_i = d;
        eof = eof_too; vbl_int = vbl_too;
        n = 0;
        do begin
            @(negedge clk);
            eof = 1'b0; vbl_int = 1'b0;
            n++;
        end while (!bus.ack && n < 8);
        chk("ack_latency", 168'(n), 168'(1));
        bus.cs = 1'b0;
        pre = m_pend;
        if (w) m_write(a, d);
        if (vbl_too) m_vbl = 1'b1;
        if (eof_too && pre && m_pend) m_apply();
        @(negedge clk);
        chk("ack_pulse", 168'(bus.ack), 168'(0));
    endtask

    task automatic eof_pulse(input bit settle);
        eof = 1'b1;
        @(negedge clk);
        eof = 1'b0;
        m_apply();
        if (settle) @(negedge clk);
    endtask

    task automatic vbl_pulse();
        vbl_int = 1'b1;
        @(negedge clk);
        vbl_int = 1'b0;
        m_vbl = 1'b1;
    endtask

    task automatic chk_out();
        @(negedge clk);
        chk("tim_o",   tim_o,            m_tim());
        chk("pending", 168'(pending),    168'(m_pend));
        chk("irq",     168'(irq),        168'(m_irq()));
    endtask

    // Monitor: every read acknowledgement pops one expected word
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.ack && !bus.we) begin
                if (sb_q.size() == 0) chk("sb_unexpected_ack", 168'(1), 168'(0));
                else                  chk("rd_data", 168'(bus.dat_o), 168'(sb_q.pop_front()));
            end else if (!bus.ack) begin
                chk("dat_o_idle", 168'(bus.dat_o), 168'(0));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; eof = 1'b0; vbl_int = 1'b0;
        bus.cs = 1'b0; bus.we = 1'b0; bus.adr = '0; bus.dat_i = '0;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_ack",   168'(bus.ack),   168'(0));
        chk("rst_dat_o", 168'(bus.dat_o), 168'(0));
        rst_n = 1'b1;
        chk_out();

        // Reset values readable, htotal on top of tim_o
        bus_xfer(1'b0, 4'd0, '0, 0, 0);
        bus_xfer(1'b0, 4'd1, '0, 0, 0);
        chk("tim_htotal", 168'(tim_o[167:156]), 168'(800));

        // Back-to-back reads with cs held: ack every second clock
        sb_q.push_back(m_read(4'd1));
        sb_q.push_back(m_read(4'd1));
        bus.cs = 1'b1; bus.we = 1'b0; bus.adr = 4'd1;
        @(negedge clk); chk("b2b_ack1", 168'(bus.ack), 168'(1));
        @(negedge clk); chk("b2b_gap",  168'(bus.ack), 168'(0));
        @(negedge clk); chk("b2b_ack2", 168'(bus.ack), 168'(1));
        bus.cs = 1'b0;
        @(negedge clk);

        // Commit applies on eof
        bus_xfer(1'b1, 4'd14, 12'h002, 0, 0);
        bus_xfer(1'b1, 4'd0, 12'd1056, 0, 0);
        bus_xfer(1'b1, 4'd14, 12'h003, 0, 0);
        chk_out();
        repeat (3) chk_out();
        eof_pulse(1'b1);
        chk("tim_htotal_new", 168'(tim_o[167:156]), 168'(1056));
        chk_out();
        bus_xfer(1'b0, 4'd15, '0, 0, 0);
        bus_xfer(1'b1, 4'd15, 12'h002, 0, 0);
        chk_out();

        // Abort discards the commit
        bus_xfer(1'b1, 4'd0, 12'd900, 0, 0);
        bus_xfer(1'b1, 4'd14, 12'h003, 0, 0);
        bus_xfer(1'b1, 4'd14, 12'h00A, 0, 0);
        chk_out();
        bus_xfer(1'b0, 4'd15, '0, 0, 0);
        eof_pulse(1'b1);
        chk_out();

        // vbl interrupt, clear, and set-wins-over-clear
        bus_xfer(1'b1, 4'd14, 12'h004, 0, 0);
        vbl_pulse();
        chk_out();
        bus_xfer(1'b1, 4'd15, 12'h004, 0, 0);
        chk_out();
        bus_xfer(1'b1, 4'd15, 12'h004, 0, 1);
        chk_out();
        bus_xfer(1'b1, 4'd15, 12'h004, 0, 0);

        // Commit coinciding with eof waits for the next eof
        bus_xfer(1'b1, 4'd14, 12'h003, 1, 0);
        chk_out();
        eof_pulse(1'b1);
        chk_out();

        // Shadow write on the apply edge lands only in the shadow
        bus_xfer(1'b1, 4'd14, 12'h003, 0, 0);
        eof_pulse(1'b0);
        bus_xfer(1'b1, 4'd1, 12'd600, 0, 0);
        chk_out();
        bus_xfer(1'b1, 4'd14, 12'h003, 0, 0);
        eof_pulse(1'b1);
        chk_out();

        // Commit and abort together act as abort
        bus_xfer(1'b1, 4'd14, 12'h009, 0, 0);
        chk_out();

        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: bus_xfer(1'b1, 4'($urandom_range(0, 13)), 12'($urandom),
                                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
                3, 4:    bus_xfer(1'b0, 4'($urandom_range(0, 15)), '0, 0, 0);
                5:       bus_xfer(1'b1, 4'd14, 12'($urandom), $urandom_range(0, 3) == 0, 0);
                6:       bus_xfer(1'b1, 4'd15, 12'($urandom), 0, $urandom_range(0, 3) == 0);
                7:       eof_pulse(1'b1);
                8:       vbl_pulse();
                default: chk_out();
            endcase
        end
        chk_out();

        // Reset while pending discards the commit immediately
        bus_xfer(1'b1, 4'd14, 12'h000, 0, 0);
        bus_xfer(1'b1, 4'd0, 12'd1056, 0, 0);
        bus_xfer(1'b1, 4'd14, 12'h001, 0, 0);
        chk("pend_before_rst", 168'(pending), 168'(1));
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("rst_htotal", 168'(tim_o[167:156]), 168'(800));
        chk("rst_pending", 168'(pending), 168'(0));
        chk("rst_irq",     168'(irq),     168'(0));
        @(negedge clk);
        rst_n = 1'b1;
        chk_out();
        bus_xfer(1'b0, 4'd0, '0, 0, 0);
        bus_xfer(1'b0, 4'd15, '0, 0, 0);

        chk("sb_drained", 168'(sb_q.size()), 168'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter `H_TOTAL`, default 800, SHALL be the reset value of hTotal.
REQ-003 Parameter `V_TOTAL`, default 525, SHALL be the reset value of vTotal.
REQ-004 `clk` input 1: video clock; every register in the block SHALL be clocked on its rising edge.
REQ-005 `rst_n` input 1: asynchronous active-low reset.
REQ-006 `cs` input 1: bus cycle request; held high until `ack`.
REQ-007 `we` input 1: 1 = write, 0 = read.
REQ-008 `adr` input 4: register select.
REQ-009 `dat_i` input 12: write data.
REQ-010 `dat_o` output 12: read data, registered.
REQ-011 `ack` output 1: bus cycle complete.
REQ-012 `eof` input 1: end-of-frame pulse from the sync generator.
REQ-013 `vbl_int` input 1: vertical-blank pulse from the sync generator.
REQ-014 `tim_o` output 168: active timing words, each 12 bits, packed MSB to LSB in this order: hTotal, vTotal, hSyncOn, hSyncOff, vSyncOn, vSyncOff, hBlankOn, hBlankOff, vBlankOn, vBlankOff, hBorderOn, hBorderOff, vBorderOn, vBorderOff.
REQ-015 `irq` output 1: level interrupt.
REQ-016 `pending` output 1: a commit is waiting for a frame boundary.

Function
REQ-017 The block SHALL hold 14 shadow registers and 14 active registers.
- Shadow registers occupy `adr` 0-13, in the same order as `tim_o`.
- Active registers drive `tim_o` directly.
REQ-018 `adr` 14 (CTRL) SHALL be laid out as follows.
- Bit 0 `commit`: write-1 only; reads as 0.
- Bit 1 `done_ie`: read/write.
- Bit 2 `vbl_ie`: read/write.
- Bit 3 `abort`: write-1 only; reads as 0.
REQ-019 `adr` 15 (STAT) SHALL be laid out as follows.
- Bit 0 `pending`: read-only.
- Bit 1 `done`: write-1-to-clear.
- Bit 2 `vbl`: write-1-to-clear.
- Bits 11:3 read as 0.
REQ-020 Bus handshake SHALL work as follows.
- `ack` rises one cycle after `cs` is sampled high while `ack` is low.
- `ack` stays high for exactly one cycle.
- A write takes effect on the `ack` edge.
- `dat_o` is valid while `ack` is high and is 0 otherwise.
- With `cs` held high, back-to-back cycles complete every 2 clocks.
REQ-021 The controller SHALL implement an FSM with states IDLE, PENDING and APPLY.
REQ-022 In IDLE, a commit write SHALL move the FSM to PENDING; `eof` SHALL be ignored.
REQ-023 In PENDING, `eof`=1 SHALL move the FSM to APPLY on the next edge.
REQ-024 In PENDING, an abort write SHALL return the FSM to IDLE with the active registers unchanged and `done` not set.
REQ-025 In PENDING, a second commit write SHALL have no additional effect.
REQ-026 In APPLY, all 14 active registers SHALL be loaded from the shadow values present at that edge, `done` SHALL be set, and the FSM SHALL return to IDLE, all in one cycle.
REQ-027 `pending` SHALL be 1 in PENDING and APPLY, and 0 in IDLE.
REQ-028 Shadow writes SHALL be accepted in all states.
- A write landing on the APPLY edge updates only the shadow copy.
- That write reaches the active registers at the next commit.
REQ-029 A commit write and `eof` on the same cycle while in IDLE SHALL enter PENDING; the apply waits for the following `eof`.
REQ-030 Commit and abort written together SHALL be treated as abort, leaving the FSM in IDLE.
REQ-031 `vbl` SHALL be set on every cycle `vbl_int`=1.
REQ-032 When set-by-hardware and clear-by-software hit the same cycle, set SHALL win, for both `done` and `vbl`.
REQ-033 `irq` SHALL be registered and equal (`done` & `done_ie`) | (`vbl` & `vbl_ie`).
REQ-034 Writes SHALL store `dat_i` unmodified; no range checking SHALL be performed.
REQ-035 Reads of CTRL SHALL return {9'b0, vbl_ie, done_ie, 1'b0}.

Reset
REQ-036 On `rst_n` low, the block SHALL asynchronously enter IDLE and drive `ack`=0, `dat_o`=0, `irq`=0, `pending`=0, with `done`, `vbl`, `done_ie` and `vbl_ie` all 0.
REQ-037 On `rst_n` low, both the shadow and the active registers SHALL be loaded with the following values.
- hTotal = `H_TOTAL`; vTotal = `V_TOTAL`.
- hSyncOn = 657, hSyncOff = 753.
- vSyncOn = 491, vSyncOff = 493.
- hBlankOn = 641, hBlankOff = 1.
- vBlankOn = 481, vBlankOff = 1.
- hBorderOn = 641, hBorderOff = 1.
- vBorderOn = 481, vBorderOff = 1.
REQ-038 A reset asserted in PENDING or APPLY SHALL discard the commit, with no partial active-register update.

Verification
REQ-039 Release reset, then read `adr` 0 and 1 -> returns 800 and 525; `tim_o`[167:156] = 800.
REQ-040 Write `adr` 0 = 1056, then write CTRL = 0x003 -> `pending`=1 and `tim_o` unchanged until `eof`; 2 cycles after `eof`, hTotal = 1056, `done`=1, `irq`=1.
REQ-041 Commit, then write abort before `eof` -> `pending`=0, `tim_o` unchanged, `done`=0.
REQ-042 Pulse `vbl_int` with `vbl_ie`=1 -> `irq`=1; write STAT = 0x004 -> `irq`=0; if `vbl_int` hits the same cycle as the clear, `irq` stays 1.
REQ-043 Write commit on the same cycle as `eof` -> no apply; the apply happens on the next `eof` only.
REQ-044 Drop `rst_n` in PENDING with shadow hTotal = 1056 -> hTotal = 800 immediately, `pending`=0.
